// File: rtl/voice_scheduler.sv
// -----------------------------------------------------------------------------
// voice_scheduler
// Wavetable voice scheduler. Once per audio sample tick it advances every
// voice's 32-bit phase accumulator, issues one wavetable ROM read per voice
// (voice 0 upward, one per clock), sums the returning samples of gated voices
// and publishes the sum as a one-clock mix_valid pulse.
//
// Ports
//   clk        : system clock, rising edge
//   nreset     : synchronous active-low reset
//   cfg_we     : voice config write strobe (accepted in any state)
//   cfg_voice  : voice index for the config write
//   cfg_inc    : phase increment written to the voice
//   cfg_gate   : note gate written to the voice (1 = on)
//   rom_rd     : ROM read issue strobe
//   rom_addr   : ROM address = accumulator bits [31:10]
//   rom_q      : ROM data, valid ROM_LATENCY clocks after rom_rd
//   mix_out    : unsigned sum of gated voice samples (held between frames)
//   mix_valid  : one-clock pulse when mix_out is updated
//   busy       : high while a sample frame is in progress
// -----------------------------------------------------------------------------
module voice_scheduler #(
    parameter int NUM_VOICES  = 8,
    parameter int ROM_LATENCY = 2,
    parameter int SAMPLE_DIV  = 100,
    parameter int DATA_W      = 24
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
    input  logic [31:0]                   cfg_inc,
    input  logic                          cfg_gate,
    output logic                          rom_rd,
    output logic [21:0]                   rom_addr,
    input  logic [DATA_W-1:0]             rom_q,
    output logic [DATA_W+2:0]             mix_out,
    output logic                          mix_valid,
    output logic                          busy
);

    localparam int VW = $clog2(NUM_VOICES);
    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int L  = ROM_LATENCY;
    localparam logic [VW-1:0] LAST_VOICE = VW'(NUM_VOICES - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [VW-1:0]           vidx_q, vidx_d;
    logic [31:0]             acc_q [NUM_VOICES];
    logic [31:0]             acc_d [NUM_VOICES];
    logic [31:0]             inc_q [NUM_VOICES];
    logic [31:0]             inc_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]   gate_q, gate_d;
    // Gates as they stood at the tick; the frame mixes with these so that a
    // config write during the frame only takes effect on the next tick.
    logic [NUM_VOICES-1:0]   fgate_q, fgate_d;
    logic [DATA_W+2:0]       sum_q, sum_d;
    // Return pipeline: valid / gate / last-voice flags, one stage per clock of
    // ROM latency behind the registered read strobe.
    logic [L-1:0]            pv_q, pv_d, pg_q, pg_d, pl_q, pl_d;
    logic                    rom_rd_q, rom_rd_d;
    logic [21:0]             rom_addr_q, rom_addr_d;
    logic                    rom_gate_q, rom_gate_d;
    logic                    rom_last_q, rom_last_d;
    logic [DATA_W+2:0]       mix_out_q, mix_out_d;
    logic                    mix_valid_q, mix_valid_d;
    logic                    busy_q, busy_d;
    logic                    tick_s;

    assign tick_s    = (cnt_q == CNT_MAX);
    assign rom_rd    = rom_rd_q;
    assign rom_addr  = rom_addr_q;
    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign busy      = busy_q;

    // Next-state: sample counter, voice config, accumulators, FSM, mixing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = tick_s ? '0 : cnt_q + CW'(1);
        vidx_d      = vidx_q;
        acc_d       = acc_q;
        inc_d       = inc_q;
        gate_d      = gate_q;
        fgate_d     = fgate_q;
        sum_d       = sum_q;
        rom_rd_d    = 1'b0;
        rom_addr_d  = 22'd0;
        rom_gate_d  = 1'b0;
        rom_last_d  = 1'b0;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        busy_d      = 1'b0;

        // Return pipeline shifts every clock; stage 0 follows the issued read.
        pv_d[0] = rom_rd_q;
        pg_d[0] = rom_gate_q;
        pl_d[0] = rom_last_q;
        for (int i = 1; i < L; i++) begin
            pv_d[i] = pv_q[i-1];
            pg_d[i] = pg_q[i-1];
            pl_d[i] = pl_q[i-1];
        end

        if (cfg_we) begin
            inc_d[cfg_voice]  = cfg_inc;
            gate_d[cfg_voice] = cfg_gate;
        end else begin
            inc_d = inc_q;
        end

        // Tick advances uses the pre-edge inc/gate, never the write above.
        if (tick_s) begin
            fgate_d = gate_q;
            for (int v = 0; v < NUM_VOICES; v++) begin
                acc_d[v] = gate_q[v] ? acc_q[v] + inc_q[v] : 32'd0;
            end
        end else begin
            fgate_d = fgate_q;
        end

        if (pv_q[L-1] && pg_q[L-1]) begin
            sum_d = sum_q + {3'b000, rom_q};
        end else begin
            sum_d = sum_q;
        end

        case (state_q)
            IDLE: begin
                if (tick_s) begin
                    state_d = ISSUE;
                    vidx_d  = '0;
                    sum_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (vidx_q == LAST_VOICE) begin
                    state_d = DRAIN;
                end else begin
                    vidx_d = vidx_q + VW'(1);
                end
            end
            DRAIN: begin
                if (pv_q[L-1] && pl_q[L-1]) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from next-state values.
        if (state_d == ISSUE) begin
            rom_rd_d   = 1'b1;
            rom_addr_d = acc_d[vidx_d][31:10];
            rom_gate_d = fgate_d[vidx_d];
            rom_last_d = (vidx_d == LAST_VOICE);
        end else begin
            rom_rd_d = 1'b0;
        end

        if (state_d == DONE) begin
            mix_valid_d = 1'b1;
            mix_out_d   = sum_d;
        end else begin
            mix_valid_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            vidx_q      <= '0;
            gate_q      <= '0;
            fgate_q     <= '0;
            sum_q       <= '0;
            pv_q        <= '0;
            pg_q        <= '0;
            pl_q        <= '0;
            rom_rd_q    <= 1'b0;
            rom_addr_q  <= 22'd0;
            rom_gate_q  <= 1'b0;
            rom_last_q  <= 1'b0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                acc_q[v] <= 32'd0;
                inc_q[v] <= 32'd0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vidx_q      <= vidx_d;
            gate_q      <= gate_d;
            fgate_q     <= fgate_d;
            sum_q       <= sum_d;
            pv_q        <= pv_d;
            pg_q        <= pg_d;
            pl_q        <= pl_d;
            rom_rd_q    <= rom_rd_d;
            rom_addr_q  <= rom_addr_d;
            rom_gate_q  <= rom_gate_d;
            rom_last_q  <= rom_last_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            busy_q      <= busy_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                acc_q[v] <= acc_d[v];
                inc_q[v] <= inc_d[v];
            end
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// -----------------------------------------------------------------------------
// tb_voice_scheduler
// Directed self-checking bench for voice_scheduler at default parameters.
// ROM model: latency 2, q = zero-extended address, or all-ones in max mode.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_voice_scheduler;

    localparam int NV  = 8;
    localparam int DIV = 100;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_voice = 3'd0;
    logic [31:0] cfg_inc = 32'd0;
    logic        cfg_gate = 1'b0;
    logic        rom_rd;
    logic [21:0] rom_addr;
    logic [23:0] rom_q;
    logic [26:0] mix_out;
    logic        mix_valid;
    logic        busy;

    logic        max_mode = 1'b0;
    logic [21:0] d1, d2;

    int errors = 0;
    int checks = 0;

    // Captured frame observations.
    logic        cap_ok, cap_rd_ok, cap_early, cap_vld10, cap_late, cap_busy_ok;
    logic [21:0] cap_addr [NV];
    logic [26:0] cap_mix;

    voice_scheduler dut (
        .clk(clk), .nreset(nreset), .cfg_we(cfg_we), .cfg_voice(cfg_voice),
        .cfg_inc(cfg_inc), .cfg_gate(cfg_gate), .rom_rd(rom_rd),
        .rom_addr(rom_addr), .rom_q(rom_q), .mix_out(mix_out),
        .mix_valid(mix_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Two-clock ROM model.
    always @(posedge clk) begin
        d1 <= rom_addr;
        d2 <= d1;
    end
    assign rom_q = max_mode ? 24'hFF_FFFF : {2'b00, d2};

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at the falling edge of post-reset cycle 0 (counter = 0).
    task automatic do_reset;
        @(negedge clk);
        cfg_we = 1'b0;
        nreset = 1'b0;
        step();
        step();
        nreset = 1'b1;
    endtask

    task automatic cfg_write(input int v, input logic [31:0] inc, input logic g);
        cfg_we    = 1'b1;
        cfg_voice = v[2:0];
        cfg_inc   = inc;
        cfg_gate  = g;
        step();
        cfg_we    = 1'b0;
    endtask

    // Waits for the first issue cycle (T+1) and records one frame; ends at T+12.
    task automatic capture_frame;
        cap_ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (rom_rd === 1'b1) begin
                cap_ok = 1'b1;
                break;
            end
            step();
        end
        cap_rd_ok = 1'b1; cap_early = 1'b0; cap_busy_ok = 1'b1;
        cap_vld10 = 1'b0; cap_late = 1'b0; cap_mix = 27'd0;
        for (int k = 0; k < 12; k++) begin
            if (k < NV) begin
                cap_addr[k] = rom_addr;
                if (rom_rd !== 1'b1) cap_rd_ok = 1'b0;
            end else if (rom_rd !== 1'b0) begin
                cap_rd_ok = 1'b0;
            end
            if (k < 10 && mix_valid !== 1'b0) cap_early = 1'b1;
            if (k == 10) begin
                cap_vld10 = mix_valid;
                cap_mix   = mix_out;
            end
            if (k == 11) cap_late = mix_valid;
            if (busy !== (k < 11)) cap_busy_ok = 1'b0;
            if (k < 11) step();
        end
    endtask

    task automatic test_reset;
        int first;
        logic [26:0] zero_mix;
        do_reset();
        checks++;
        if ({rom_rd, rom_addr, mix_valid, busy} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%0b addr=%h vld=%0b busy=%0b, want all 0",
                     rom_rd, rom_addr, mix_valid, busy);
        end
        zero_mix = 27'd0;
        checks++;
        if (mix_out !== zero_mix) begin
            errors++;
            $display("FAIL reset_mix_out: got %h want 0", mix_out);
        end
        first = 0;
        for (int i = 1; i < 300; i++) begin
            step();
            if (rom_rd === 1'b1) begin
                first = i;
                break;
            end
        end
        checks++;
        if (first != DIV) begin
            errors++;
            $display("FAIL first_issue_cycle: got %0d want %0d", first, DIV);
        end
        // All voices gated off: full frame, sum zero.
        capture_frame();
        checks++;
        if ({cap_ok, cap_rd_ok, ~cap_early, cap_vld10, ~cap_late, cap_busy_ok} !== 6'b111111) begin
            errors++;
            $display("FAIL gated_off_timing: got %b want 111111",
                     {cap_ok, cap_rd_ok, ~cap_early, cap_vld10, ~cap_late, cap_busy_ok});
        end
        checks++;
        if (cap_mix !== 27'd0) begin
            errors++;
            $display("FAIL gated_off_mix: got %h want 0", cap_mix);
        end
    endtask

    task automatic test_single_voice;
        do_reset();
        cfg_write(0, 32'h0000_0400, 1'b1);
        for (int f = 1; f <= 2; f++) begin
            capture_frame();
            checks++;
            if ({cap_ok, cap_rd_ok, ~cap_early, cap_vld10, ~cap_late, cap_busy_ok} !== 6'b111111) begin
                errors++;
                $display("FAIL single_timing f%0d: got %b want 111111", f,
                         {cap_ok, cap_rd_ok, ~cap_early, cap_vld10, ~cap_late, cap_busy_ok});
            end
            checks++;
            if (cap_addr[0] !== 22'(f) || cap_addr[1] !== 22'd0) begin
                errors++;
                $display("FAIL single_addr f%0d: got %h,%h want %h,0", f, cap_addr[0], cap_addr[1], f);
            end
            checks++;
            if (cap_mix !== 27'(f)) begin
                errors++;
                $display("FAIL single_mix f%0d: got %0d want %0d", f, cap_mix, f);
            end
        end
    endtask

    task automatic test_all_voices;
        do_reset();
        for (int v = 0; v < NV; v++) cfg_write(v, 32'h0000_0400 * (v + 1), 1'b1);
        for (int f = 1; f <= 2; f++) begin
            capture_frame();
            for (int v = 0; v < NV; v++) begin
                checks++;
                if (cap_addr[v] !== 22'(f * (v + 1))) begin
                    errors++;
                    $display("FAIL all_addr f%0d v%0d: got %0d want %0d", f, v, cap_addr[v], f * (v + 1));
                end
            end
            checks++;
            if (cap_mix !== 27'(36 * f)) begin
                errors++;
                $display("FAIL all_mix f%0d: got %0d want %0d", f, cap_mix, 36 * f);
            end
        end
    endtask

    task automatic test_wrap;
        logic [21:0] exp_a [3];
        exp_a[0] = 22'h20_0000;
        exp_a[1] = 22'h00_0000;
        exp_a[2] = 22'h20_0000;
        do_reset();
        cfg_write(3, 32'h8000_0000, 1'b1);
        for (int f = 0; f < 3; f++) begin
            capture_frame();
            checks++;
            if (cap_addr[3] !== exp_a[f] || cap_mix !== {5'd0, exp_a[f]}) begin
                errors++;
                $display("FAIL wrap f%0d: got addr=%h mix=%h want addr=%h mix=%h",
                         f, cap_addr[3], cap_mix, exp_a[f], exp_a[f]);
            end
        end
    endtask

    task automatic test_cfg_at_tick;
        do_reset();
        cfg_write(0, 32'h0000_0400, 1'b1);
        // Now in cycle 1; the tick cycle is DIV-1.
        repeat (DIV - 2) step();
        checks++;
        if (rom_rd !== 1'b0) begin
            errors++;
            $display("FAIL tick_pre_rd: got %0b want 0", rom_rd);
        end
        cfg_write(0, 32'h0000_0400, 1'b0);
        checks++;
        if (rom_rd !== 1'b1) begin
            errors++;
            $display("FAIL tick_post_rd: got %0b want 1", rom_rd);
        end
        capture_frame();
        checks++;
        if (cap_addr[0] !== 22'd1 || cap_mix !== 27'd1) begin
            errors++;
            $display("FAIL cfg_tick_f1: got addr=%0d mix=%0d want 1,1", cap_addr[0], cap_mix);
        end
        capture_frame();
        checks++;
        if (cap_addr[0] !== 22'd0 || cap_mix !== 27'd0 || cap_vld10 !== 1'b1) begin
            errors++;
            $display("FAIL cfg_tick_f2: got addr=%0d mix=%0d vld=%0b want 0,0,1",
                     cap_addr[0], cap_mix, cap_vld10);
        end
    endtask

    task automatic test_max;
        do_reset();
        for (int v = 0; v < NV; v++) cfg_write(v, 32'd0, 1'b1);
        max_mode = 1'b1;
        capture_frame();
        max_mode = 1'b0;
        checks++;
        if (cap_mix !== 27'h7FF_FFF8 || cap_vld10 !== 1'b1) begin
            errors++;
            $display("FAIL max_mix: got %h vld=%0b want 7fffff8 vld=1", cap_mix, cap_vld10);
        end
    endtask

    task automatic test_reset_mid_frame;
        int first;
        logic [26:0] mix_seen;
        do_reset();
        cfg_write(0, 32'h0000_0400, 1'b1);
        max_mode = 1'b1;
        first = 0;
        for (int n = 0; n < 200; n++) begin
            if (rom_rd === 1'b1) break;
            step();
        end
        repeat (4) step();
        nreset = 1'b0;
        step();
        checks++;
        if ({rom_rd, rom_addr, mix_valid, busy} !== 25'd0 || mix_out !== 27'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got rd=%0b addr=%h vld=%0b busy=%0b mix=%h want all 0",
                     rom_rd, rom_addr, mix_valid, busy, mix_out);
        end
        nreset = 1'b1;
        mix_seen = 27'd0;
        for (int i = 1; i < 300; i++) begin
            step();
            if (mix_valid === 1'b1) begin
                first = i;
                mix_seen = mix_out;
                break;
            end
        end
        max_mode = 1'b0;
        // Tick falls in post-reset cycle DIV-1, mix_valid eleven cycles later.
        checks++;
        if (first != DIV + 10) begin
            errors++;
            $display("FAIL midreset_next_valid: got cycle %0d want %0d", first, DIV + 10);
        end
        checks++;
        if (mix_seen !== 27'd0) begin
            errors++;
            $display("FAIL midreset_mix: got %h want 0", mix_seen);
        end
    endtask

    initial begin
        test_reset();
        test_single_voice();
        test_all_voices();
        test_wrap();
        test_cfg_at_tick();
        test_max();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
